// File: rtl/load_store_unit.sv
// Byte-addressed MIPS load/store front end for a word-addressed, big-endian data port.
// Sub-word stores use read-modify-write; every request ends in a one-cycle response pulse.
module load_store_unit #(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_SIZE  = 256,
  localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [MEM_WIDTH-1:0] resp_rdata,
  output logic                 resp_fault,
  output logic [AW-1:0]        mem_addr_data,
  output logic                 mem_read_en_data,
  output logic                 mem_write_en_data,
  output logic [MEM_WIDTH-1:0] mem_write_val_data,
  input  logic [MEM_WIDTH-1:0] mem_read_val_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e               r_state, w_state;
  logic                 r_write, w_write;
  logic [1:0]           r_size, w_size;
  logic                 r_uns, w_uns;
  logic [1:0]           r_off, w_off;
  logic [15:0]          r_wdata, w_wdata;
  logic [AW-1:0]        r_addr, w_addr;
  logic                 r_rd_en, w_rd_en;
  logic                 r_wr_en, w_wr_en;
  logic [MEM_WIDTH-1:0] r_wval, w_wval;
  logic [MEM_WIDTH-1:0] r_rdata, w_rdata;
  logic                 r_fault, w_fault;

  logic          w_req_fault;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;

  // Byte lane 0 is the most significant byte, hence the inverted offsets.
  function automatic logic [MEM_WIDTH-1:0] f_extract(input logic [MEM_WIDTH-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic uns,
                                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{~off, 3'b000} +: 8];
    h = word[{~off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [MEM_WIDTH-1:0] f_merge(input logic [MEM_WIDTH-1:0] word,
                                                   input logic [15:0] wdata,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [MEM_WIDTH-1:0] res;
    res = word;
    case (size)
      2'b00:   res[{~off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   res[{~off[1], 4'b0000} +: 16] = wdata;
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_idx         = req_addr[AW+1:2];
  assign w_unused_addr = ^req_addr[31:AW+2];
  assign w_req_fault   = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_addr[0]) ||
                         (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    w_state = r_state;
    w_write = r_write;
    w_size  = r_size;
    w_uns   = r_uns;
    w_off   = r_off;
    w_wdata = r_wdata;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_addr  = r_addr;
    w_wval  = r_wval;
    w_rdata = r_rdata;
    w_fault = r_fault;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_write = req_write;
          w_size  = req_size;
          w_uns   = req_unsigned;
          w_off   = req_addr[1:0];
          w_wdata = req_wdata[15:0];
          w_fault = w_req_fault;
          w_rdata = '0;
          if (w_req_fault) begin
            w_state = StResp;
          end else if (req_write && req_size == 2'b10) begin
            w_state = StWr;
            w_wr_en = 1'b1;
            w_addr  = w_idx;
            w_wval  = req_wdata;
          end else begin
            w_state = StRd;
            w_rd_en = 1'b1;
            w_addr  = w_idx;
          end
        end
      end
      StRd: begin
        if (r_write) begin
          w_state = StWr;
          w_wr_en = 1'b1;
          w_wval  = f_merge(mem_read_val_data, r_wdata, r_size, r_off);
        end else begin
          w_state = StResp;
          w_rdata = f_extract(mem_read_val_data, r_size, r_uns, r_off);
        end
      end
      StWr:    w_state = StResp;
      StResp:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_write <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_wdata <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_wval  <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_write <= w_write;
      r_size  <= w_size;
      r_uns   <= w_uns;
      r_off   <= w_off;
      r_wdata <= w_wdata;
      r_addr  <= w_addr;
      r_rd_en <= w_rd_en;
      r_wr_en <= w_wr_en;
      r_wval  <= w_wval;
      r_rdata <= w_rdata;
      r_fault <= w_fault;
    end
  end

  assign req_ready          = (r_state == StIdle);
  assign resp_valid         = (r_state == StResp);
  assign resp_rdata         = r_rdata;
  assign resp_fault         = r_fault;
  assign mem_addr_data      = r_addr;
  assign mem_read_en_data   = r_rd_en;
  assign mem_write_en_data  = r_wr_en;
  assign mem_write_val_data = r_wval;

endmodule
